// File: rtl/dh_key_controller_if.sv
`default_nettype none
// ============================================================================
//  Module      : dh_key_controller_if
//  Description : Start/done handshake between the DH key controller
//                (master) and the modular exponentiation engine (slave).
//                  exp_start    - engine request, level
//                  exp_base     - engine base operand
//                  exp_exponent - engine exponent operand
//                  exp_result   - engine raw 2*W-bit result
//                  exp_done     - engine completion, level
//  Revision    : 1.0  initial release
// ============================================================================
interface dh_key_controller_if #(
    parameter int W = 32
);
    logic             exp_start;
    logic [W-1:0]     exp_base;
    logic [W-1:0]     exp_exponent;
    logic [2*W-1:0]   exp_result;
    logic             exp_done;

    modport master (
        output exp_start,
        output exp_base,
        output exp_exponent,
        input  exp_result,
        input  exp_done
    );

    modport slave (
        input  exp_start,
        input  exp_base,
        input  exp_exponent,
        output exp_result,
        output exp_done
    );
endinterface
`default_nettype wire

// File: rtl/dh_key_controller.sv
`default_nettype none
// ============================================================================
//  Module      : dh_key_controller
//  Description : Initiator side of the exponentiation engine in the
//                Diffie-Hellman datapath. Accepts a key-exchange command,
//                runs the engine through its start/done handshake, then
//                reduces the 2*W-bit raw result modulo p with a bit-serial
//                restoring reducer and returns g^a mod p or B^a mod p.
//  Ports       : clk, rst       - clock, asynchronous active-high reset
//                op_start       - command strobe (sampled in IDLE only)
//                op_sel         - 0: base = gen, 1: base = peer_pub
//                gen, peer_pub  - generator g / peer public key B
//                priv_key       - private exponent a
//                prime          - modulus p (0 is rejected with error)
//                eng            - engine handshake (master modport)
//                busy           - high in every state except IDLE
//                key_out        - reduced result, held between commands
//                done / error   - one-cycle completion / abort pulses
//  Revision    : 1.0  initial release
// ============================================================================
module dh_key_controller #(
    parameter int W       = 32,
    parameter int TIMEOUT = 4096
) (
    input  wire              clk,
    input  wire              rst,
    input  wire              op_start,
    input  wire              op_sel,
    input  wire [W-1:0]      gen,
    input  wire [W-1:0]      peer_pub,
    input  wire [W-1:0]      priv_key,
    input  wire [W-1:0]      prime,
    dh_key_controller_if.master eng,
    output logic             busy,
    output logic [W-1:0]     key_out,
    output logic             done,
    output logic             error
);

    // One counter serves both the engine wait and the reduction loop.
    localparam int c_CNT_MAX = (TIMEOUT > 2*W) ? TIMEOUT : 2*W;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
    localparam logic [c_CNT_W-1:0] c_TO_LAST  = c_CNT_W'(TIMEOUT - 1);
    localparam logic [c_CNT_W-1:0] c_RED_LAST = c_CNT_W'(2*W - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SETUP   = 3'd1;
    localparam logic [2:0] S_REQ     = 3'd2;
    localparam logic [2:0] S_RELEASE = 3'd3;
    localparam logic [2:0] S_REDUCE  = 3'd4;
    localparam logic [2:0] S_FINISH  = 3'd5;

    logic [2:0]         r_state;
    logic [2:0]         w_state_next;
    logic [W-1:0]       r_base;
    logic [W-1:0]       r_exp;
    logic [W-1:0]       r_prime;
    logic [2*W-1:0]     r_div;
    logic [W-1:0]       r_rem;
    logic [W-1:0]       r_key;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_error;

    logic [W:0]         w_shift;
    logic [W-1:0]       w_rem_next;

    // Restoring step: bring in the next dividend bit, subtract p if it fits.
    // The remainder stays below p, so W bits of the difference suffice.
    assign w_shift    = {r_rem, r_div[2*W-1]};
    assign w_rem_next = (w_shift >= {1'b0, r_prime}) ? (w_shift[W-1:0] - r_prime)
                                                     : w_shift[W-1:0];

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next state and state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        busy         = 1'b1;
        eng.exp_start = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (op_start && (prime != '0)) begin
                    w_state_next = S_SETUP;
                end
            end
            S_SETUP: begin
                w_state_next = S_REQ;
            end
            S_REQ: begin
                eng.exp_start = 1'b1;
                if (eng.exp_done) begin
                    w_state_next = S_RELEASE;
                end else if (r_cnt == c_TO_LAST) begin
                    w_state_next = S_IDLE;
                end
            end
            S_RELEASE: begin
                w_state_next = S_REDUCE;
            end
            S_REDUCE: begin
                if (r_cnt == c_RED_LAST) begin
                    w_state_next = S_FINISH;
                end
            end
            S_FINISH: begin
                done         = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                busy         = 1'b0;
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_base  <= '0;
            r_exp   <= '0;
            r_prime <= '0;
            r_div   <= '0;
            r_rem   <= '0;
            r_key   <= '0;
            r_cnt   <= '0;
            r_error <= 1'b0;
        end else begin
            r_error <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (op_start) begin
                        r_base  <= op_sel ? peer_pub : gen;
                        r_exp   <= priv_key;
                        r_prime <= prime;
                        // A zero modulus has no residue: reject immediately.
                        if (prime == '0) begin
                            r_error <= 1'b1;
                        end
                    end
                end
                S_SETUP: begin
                    r_cnt <= '0;
                end
                S_REQ: begin
                    if (eng.exp_done) begin
                        r_div <= eng.exp_result;
                    end else if (r_cnt == c_TO_LAST) begin
                        r_error <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RELEASE: begin
                    r_cnt <= '0;
                    r_rem <= '0;
                end
                S_REDUCE: begin
                    r_rem <= w_rem_next;
                    r_div <= {r_div[2*W-2:0], 1'b0};
                    r_cnt <= r_cnt + 1'b1;
                    // Publish on the last step so key_out is valid with done.
                    if (r_cnt == c_RED_LAST) begin
                        r_key <= w_rem_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign eng.exp_base     = r_base;
    assign eng.exp_exponent = r_exp;
    assign key_out          = r_key;
    assign error            = r_error;

endmodule
`default_nettype wire

// File: doc/dh_key_controller.md
Name: dh_key_controller

Overview:
- Initiator side of the exponentiation engine's start/done interface in the Diffie-Hellman datapath.
- Accepts a key-exchange command and drives base/exponent/start to the engine, then holds start until done.
- Captures the engine's 64-bit raw result and reduces it modulo the prime p with a sequential restoring reducer.
- Returns a 32-bit public key (g^a mod p) or shared secret (B^a mod p) with a done pulse.

Parameters:
- W, 32, operand width (base, exponent, modulus, reduced result); engine result width is 2*W.
- TIMEOUT, 4096, max cycles to wait for exp_done before aborting with error.

Ports:
- clk  in  1  clock.
- rst  in  1  reset. One clock; asynchronous, active-high.
- op_start  in  1  single-cycle command strobe; sampled only in IDLE.
- op_sel  in  1  0 = public key (base = gen), 1 = shared secret (base = peer_pub).
- gen  in  W  generator g.
- peer_pub  in  W  peer public key B.
- priv_key  in  W  private exponent a.
- prime  in  W  modulus p.
- exp_start  out  1  engine request, level.
- exp_base  out  W  engine base.
- exp_exponent  out  W  engine exponent.
- exp_result  in  2W  engine raw result.
- exp_done  in  1  engine completion, level.
- busy  out  1  high in every state except IDLE.
- key_out  out  W  reduced result, held until the next accepted command.
- done  out  1  one-cycle completion pulse.
- error  out  1  one-cycle pulse on abort.

Behaviour:
- Reset (async, any state): all outputs 0; FSM to IDLE; internal registers cleared.
- States: IDLE, SETUP, REQ, RELEASE, REDUCE, FINISH.
- IDLE:
  - On op_start=1, latch op_sel, gen/peer_pub, priv_key and prime into internal registers.
  - If the latched prime = 0, pulse error next cycle and stay in IDLE.
  - Otherwise go to SETUP.
  - op_start outside IDLE is ignored, not queued.
- SETUP:
  - Drive exp_base and exp_exponent from the latched values with exp_start=0 for exactly 1 cycle, so the engine loads its base.
  - Go to REQ.
- REQ:
  - exp_start=1 with operands held stable.
  - Wait counter counts from 0.
  - On exp_done=1, capture exp_result into a 2W dividend register and go to RELEASE.
  - If the counter reaches TIMEOUT with no exp_done, drop exp_start, pulse error, and return to IDLE. key_out is unchanged.
- RELEASE: exp_start=0 for 1 cycle, which returns the engine to its idle state. Go to REDUCE.
- REDUCE: restoring reduction, 2W cycles, MSB first.
  - Each cycle: r = {r[W-1:0], dividend MSB} (W+1 bits); if r >= p then r = r - p; dividend shifts left.
  - After 2W iterations, r is less than p; go to FINISH.
- FINISH: key_out = r[W-1:0]; done=1 for 1 cycle; return to IDLE.
- Latency, op_start to done: 1 (IDLE) + 1 (SETUP) + N (engine, including the cycle exp_done is seen) + 1 (RELEASE) + 2W (REDUCE) + 1 (FINISH).
- Arithmetic rules:
  - Reduction is exact for any 2W-bit exp_result.
  - p=1 gives key_out=0.
  - exp_result < p passes through unchanged.
- exp_done high in IDLE, SETUP or RELEASE is ignored.
- done and error never assert in the same cycle.
- Reset mid-operation: outputs clear immediately; no done or error pulse follows.

Test Plan:
- Public key: gen=5, priv_key=6, prime=23, op_sel=0, with the engine model returning 15625.
  - Expect exp_base=5, exp_exponent=6 during REQ.
  - Expect key_out=8, done pulse once.
  - Expect busy exactly for the computed latency.
- Shared secret: peer_pub=19, priv_key=6, prime=23, op_sel=1, with the engine returning 47045881.
  - Expect key_out=2.
  - Repeat with the peer side (peer_pub=8, priv_key=15, engine returns 8^15 = 35184372088832) and expect key_out=2.
- Boundaries:
  - exp_result=1, prime=23 -> key_out=1.
  - prime=1 -> key_out=0.
  - exp_result=2^64-1, prime=0xFFFFFFFB -> key_out=(2^64-1) mod 0xFFFFFFFB, checked against the reference model.
  - prime=0 -> error pulse, busy never asserts, exp_start never rises.
- Timeout: the engine model never raises exp_done, TIMEOUT=16.
  - Expect exp_start high for 16 cycles, then low.
  - Expect an error pulse, return to IDLE, key_out unchanged.
- Protocol and reset:
  - op_start pulsed during REQ/REDUCE -> ignored, only one done.
  - rst asserted mid-REDUCE -> all outputs 0 asynchronously.
  - A fresh command after reset completes correctly.
  - Exactly one exp_start=0 cycle in SETUP and one in RELEASE per command.
